// File: rtl/mem_arbiter_v1.sv
// rtl/mem_arbiter_v1.sv - single-port memory arbiter/sequencer for fetch and data requesters
module mem_arbiter_v1 #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [7:0]        arb_error_vector
);

    // Sparse encoding leaves unused codes so a corrupted state is detectable.
    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_ACCESS = 3'b001,
        S_WAIT   = 3'b010,
        S_RESP   = 3'b100
    } state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state, state_nxt;
    logic [3:0]        lat_cnt;
    logic [3:0]        starve_cnt;
    logic              owner_data;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] fetch_rdata_q;
    logic [DATA_W-1:0] data_rdata_q;
    logic              fetch_pend;
    logic              data_pend;
    logic [3:0]        err_q;

    logic              is_idle;
    logic              fetch_win;
    logic              lat_last;
    logic              state_illegal;
    logic [ADDR_W-1:0] win_addr;

    assign is_idle  = (state == S_IDLE);
    assign lat_last = (lat_cnt <= 4'd1);
    // Fetch only beats a pending data request once it has been passed over STARVE_LIMIT times.
    assign fetch_win = fetch_req && (!data_req || starve_cnt == STARVE_MAX);
    assign fetch_gnt = rst && is_idle && fetch_win;
    assign data_gnt  = rst && is_idle && data_req && !fetch_win;
    assign win_addr  = data_gnt ? data_addr : fetch_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        state_illegal = 1'b0;
        case (state)
            S_IDLE:   if (fetch_gnt || data_gnt) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_WAIT;
            S_WAIT:   if (lat_last) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default: begin
                state_nxt     = S_IDLE;
                state_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fetch_rvalid = 1'b0;
        data_rvalid  = 1'b0;
        if (state == S_ACCESS) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
        if (state == S_RESP) begin
            fetch_rvalid = !owner_data;
            data_rvalid  = owner_data;
        end
    end

    assign busy             = !is_idle;
    assign fetch_rdata      = fetch_rdata_q;
    assign data_rdata       = data_rdata_q;
    assign arb_error_vector = {4'b0000, err_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt       <= '0;
            starve_cnt    <= '0;
            owner_data    <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
            fetch_pend    <= 1'b0;
            data_pend     <= 1'b0;
            err_q         <= '0;
        end else begin
            if (fetch_gnt || data_gnt) begin
                owner_data <= data_gnt;
                addr_q     <= {win_addr[ADDR_W-1:2], 2'b00};
                we_q       <= data_gnt && data_we;
                wdata_q    <= data_gnt ? data_wdata : '0;
                if (win_addr[1:0] != 2'b00) err_q[3] <= 1'b1;
            end

            if (fetch_gnt) begin
                starve_cnt <= '0;
            end else if (data_gnt) begin
                starve_cnt <= fetch_req ? starve_cnt + 4'd1 : 4'd0;
            end

            if (state == S_ACCESS) begin
                lat_cnt <= LAT_INIT;
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if (state == S_WAIT && lat_last) begin
                if (!owner_data) begin
                    fetch_rdata_q <= mem_rdata;
                end else begin
                    data_rdata_q <= we_q ? '0 : mem_rdata;
                end
            end

            // A request that was outstanding last cycle must still be present.
            fetch_pend <= fetch_req && !fetch_gnt;
            data_pend  <= data_req && !data_gnt;
            if (fetch_pend && !fetch_req) err_q[0] <= 1'b1;
            if (data_pend && !data_req)   err_q[1] <= 1'b1;
            if (state_illegal)            err_q[2] <= 1'b1;
        end
    end

endmodule

// File: doc/mem_arbiter_v1.md
# mem_arbiter_v1

Single-port memory arbiter and access sequencer for the multicycle RISC-V core. It shares the one `memory_v1` port between the instruction-fetch requester (IR load path) and the data requester (load/store path). It grants one transaction at a time, drives the memory address, write data and enable for a fixed-latency access, and returns read data with a one-cycle valid pulse to the owner. Data has priority over fetch, with a starvation guard so fetch always progresses.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LATENCY`, 1, cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..15
- `STARVE_LIMIT`, 4, consecutive contended data grants before fetch is forced to win; legal range 1..15

- `clk` in 1: system clock, rising edge
- `rst` in 1: reset; asynchronous, active-low
- `fetch_req` in 1: fetch request, held until `fetch_gnt`
- `fetch_addr` in ADDR_W: fetch address
- `fetch_gnt` out 1: fetch accepted (one-cycle pulse)
- `fetch_rvalid` out 1: fetch data valid (one-cycle pulse)
- `fetch_rdata` out DATA_W: fetch read data
- `data_req` in 1: data request, held until `data_gnt`
- `data_we` in 1: 1 = store, 0 = load
- `data_addr` in ADDR_W: data address
- `data_wdata` in DATA_W: store data
- `data_gnt` out 1: data accepted (one-cycle pulse)
- `data_rvalid` out 1: load data valid or store complete (one-cycle pulse)
- `data_rdata` out DATA_W: load data
- `mem_en` out 1: memory access strobe
- `mem_we` out 1: memory write enable
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: memory read data
- `busy` out 1: a transaction is in flight (state is not IDLE)
- `arb_error_vector` out 8: sticky error flags

## Operation
- **States:** IDLE, ACCESS, WAIT, RESP. Any other encoding sets `arb_error_vector[2]` and moves to IDLE.
- **IDLE:**
  - If any request is high, pick a winner and pulse its gnt combinationally in the same cycle.
  - Latch owner, address (bits [1:0] forced to 0), `we` and `wdata`; go to ACCESS.
  - With no request, stay in IDLE.
- **Priority:**
  - Data wins over fetch unless `starve_cnt == STARVE_LIMIT`; then fetch wins and `starve_cnt` goes to 0.
  - `starve_cnt` increments on a data grant while `fetch_req` = 1.
  - `starve_cnt` clears on any fetch grant, or on a data grant while `fetch_req` = 0.
- **ACCESS (1 cycle):**
  - `mem_en` = 1 and `mem_addr`/`mem_wdata` driven from the latches.
  - `mem_we` = latched `we` (fetch is always a read).
  - Load the latency counter with `MEM_LATENCY`; go to WAIT.
- **WAIT (`MEM_LATENCY` cycles):**
  - Decrement the counter each cycle.
  - In the last WAIT cycle, capture `mem_rdata` into the owner's rdata register (stores capture 0); go to RESP.
- **RESP (1 cycle):** pulse the owner's rvalid; go to IDLE.
- **Held values:**
  - `*_rdata` holds its value until that requester's next capture.
  - `mem_*` outputs are 0 outside ACCESS.
- **Requests while busy:** gnt stays 0 and the request waits. Requesters keep req and address stable until gnt.
- **Error bits** (sticky, cleared only by reset):
  - [0] `fetch_req` fell without a grant
  - [1] `data_req` fell without a grant
  - [2] illegal state
  - [3] granted address had bits [1:0] ≠ 0
  - [7:4] = 0

## Timing
- **Reset:**
  - All outputs are 0; state IDLE; `starve_cnt` = 0; rdata registers = 0.
  - Asserting `rst` mid-transaction aborts it immediately: `mem_en` drops asynchronously and no rvalid is issued.
- **Grant:** in cycle T, the cycle in which IDLE sees the request.
- **Sequence:** ACCESS at T+1; WAIT from T+2 to T+1+MEM_LATENCY; rvalid at T+2+MEM_LATENCY.
- **Back-to-back:** the earliest next grant is T+3+MEM_LATENCY. With `MEM_LATENCY`=1: gnt T, `mem_en` T+1, rvalid T+3, next gnt T+4.
- **Simultaneous requests:** exactly one gnt per IDLE cycle. The loser keeps req high and is granted at the next IDLE.

## Test plan
- **Reset:** hold `rst`=0, then release with no requests -> all outputs 0, `busy`=0, `arb_error_vector`=0x00.
- **Single fetch:** `fetch_req` with addr 0x100, `mem_rdata`=0xDEADBEEF, `MEM_LATENCY`=1 -> `fetch_gnt` at T, `mem_en`/`mem_addr`=0x100 at T+1, `fetch_rvalid` with `fetch_rdata`=0xDEADBEEF at T+3.
- **Store:** `data_we`=1, addr 0x20, wdata 0x12345678 -> `mem_we`=1 for exactly one cycle at T+1 with those values; `data_rvalid` at T+3; `fetch_*` untouched.
- **Starvation guard:** `fetch_req` and `data_req` held continuously, `STARVE_LIMIT`=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- **Reset mid-transaction:** assert `rst` during WAIT -> `mem_en`=0 and `busy`=0 immediately; no rvalid after release; the next request is granted normally.
- **Errors:** data request to 0x22 -> `mem_addr`=0x20 and bit3 set. Drop `fetch_req` while the arbiter is busy -> bit0 set. Both flags persist until reset.
